cpu_mem_responder: RTL and testbench

Memory-side responder for the five-stage RV64 pipeline core. It answers the core's instruction fetch (`pc` → `inst`) and its data bus: it captures store data the core drives on the shared `mem_data` bus and drives load data back when the core releases the bus. A small control FSM sequences program preload, the run phase, post-halt drain, and a ready/valid dump of data memory for the checker.

---
 rtl/cpu_mem_pkg.sv | 18 +
 rtl/cpu_mem_responder_dmem_bank.sv | 36 +++
 rtl/cpu_mem_responder.sv | 142 ++++++++++++++
 tb/tb_cpu_mem_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory responder.
package cpu_mem_pkg;

    localparam int unsigned IMEM_WORDS_DEFAULT = 1024;
    localparam int unsigned DMEM_WORDS_DEFAULT = 1152;

    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam logic [31:0] HALT_INST = 32'h0000_0000;

    typedef enum logic [2:0] {
        StLoad,
        StRun,
        StDrain,
        StDump,
        StDone
    } mem_state_t;

endpackage

// File: rtl/cpu_mem_responder_dmem_bank.sv
// 64-bit data memory: one synchronous write port, asynchronous bus and dump read ports.
module dmem_bank #(
    parameter int unsigned WORDS = 1152,
    localparam int unsigned AW   = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] bus_addr,
    output logic [63:0]   bus_data,
    input  logic [AW-1:0] dump_addr,
    output logic [63:0]   dump_data
);

    logic [63:0] mem [WORDS];

    logic waddr_ok;
    logic bus_ok;
    logic dump_ok;

    // WORDS need not be a power of two, so indices past the end are guarded.
    assign waddr_ok = 32'(waddr) < WORDS;
    assign bus_ok   = 32'(bus_addr) < WORDS;
    assign dump_ok  = 32'(dump_addr) < WORDS;

    always_ff @(posedge clk) begin
        if (we && waddr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    assign bus_data  = bus_ok ? mem[bus_addr] : 64'h0;
    assign dump_data = dump_ok ? mem[dump_addr] : 64'h0;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the RV64 core: fetch, shared data bus, preload,
// post-halt drain and a ready/valid dump of data memory.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT,
    parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEFAULT,
    localparam int unsigned IAW = $clog2(IMEM_WORDS),
    localparam int unsigned DAW = $clog2(DMEM_WORDS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:0]    pc,
    output logic [31:0]    inst,
    input  logic [63:0]    addr,
    input  logic           mem_rw,
    inout  wire  [63:0]    mem_data,
    input  logic           halt,
    output logic           cpu_rst,
    input  logic           prog_we,
    input  logic           prog_sel,
    input  logic [DAW-1:0] prog_addr,
    input  logic [63:0]    prog_data,
    input  logic           start,
    output logic           dump_valid,
    input  logic           dump_ready,
    output logic [DAW-1:0] dump_addr,
    output logic [63:0]    dump_data,
    output logic           done
);

    localparam logic [31:0]    IMEM_BYTES = 32'(IMEM_WORDS) * 32'd4;
    localparam logic [63:0]    DMEM_BYTES = 64'(DMEM_WORDS) * 64'd8;
    localparam logic [DAW-1:0] LAST_WORD  = DAW'(DMEM_WORDS - 1);

    mem_state_t     state_q, state_d;
    logic [DAW-1:0] dump_addr_q, dump_addr_d;
    logic           cpu_rst_q;

    logic [31:0]    imem [IMEM_WORDS];
    logic           imem_we;

    logic [DAW-1:0] bus_idx;
    logic           bus_in_range;
    logic [63:0]    bus_rd;
    logic           bus_we;
    logic           prog_dwe;
    logic           dmem_we;
    logic [DAW-1:0] dmem_waddr;
    logic [63:0]    dmem_wdata;
    logic           dump_fire;

    // ---------------- Control FSM ----------------
    assign dump_fire = (state_q == StDump) && dump_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:  if (start) state_d = StRun;
            StRun:   if (halt) state_d = StDrain;
            StDrain: state_d = StDump;
            StDump:  if (dump_fire && dump_addr_q == LAST_WORD) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StLoad;
        endcase
    end

    // The dump index is parked at zero outside DUMP so each dump starts fresh.
    always_comb begin
        dump_addr_d = dump_addr_q;
        if (state_q != StDump) begin
            dump_addr_d = '0;
        end else if (dump_fire && dump_addr_q != LAST_WORD) begin
            dump_addr_d = dump_addr_q + DAW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StLoad;
            dump_addr_q <= '0;
            cpu_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            dump_addr_q <= dump_addr_d;
            cpu_rst_q   <= (state_d == StLoad);
        end
    end

    assign cpu_rst    = cpu_rst_q;
    assign dump_valid = (state_q == StDump);
    assign dump_addr  = dump_addr_q;
    assign done       = (state_q == StDone);

    // ---------------- Instruction memory ----------------
    // Writes are gated by rst so nothing commits on an edge while reset is held.
    assign imem_we = !rst && (state_q == StLoad) && prog_we && !prog_sel &&
                     (32'(prog_addr) < IMEM_WORDS);

    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[prog_addr[IAW-1:0]] <= prog_data[31:0];
        end
    end

    always_comb begin
        inst = NOP_INST;
        if (state_q == StRun) begin
            inst = (pc < IMEM_BYTES) ? imem[pc[IAW+1:2]] : HALT_INST;
        end
    end

    // ---------------- Data memory and shared bus ----------------
    assign bus_idx      = addr[DAW+2:3];
    assign bus_in_range = addr < DMEM_BYTES;

    assign bus_we   = !rst && mem_rw && bus_in_range &&
                      ((state_q == StRun) || (state_q == StDrain));
    assign prog_dwe = !rst && (state_q == StLoad) && prog_we && prog_sel &&
                      (32'(prog_addr) < DMEM_WORDS);

    // Bus stores and preload writes live in disjoint states, so one port suffices.
    assign dmem_we    = bus_we || prog_dwe;
    assign dmem_waddr = bus_we ? bus_idx : prog_addr;
    assign dmem_wdata = bus_we ? mem_data : prog_data;

    dmem_bank #(
        .WORDS (DMEM_WORDS)
    ) u_dmem (
        .clk       (clk),
        .we        (dmem_we),
        .waddr     (dmem_waddr),
        .wdata     (dmem_wdata),
        .bus_addr  (bus_idx),
        .bus_data  (bus_rd),
        .dump_addr (dump_addr_q),
        .dump_data (dump_data)
    );

    assign mem_data = mem_rw ? {64{1'bz}} : (bus_in_range ? bus_rd : 64'h0);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized self-checking bench for cpu_mem_responder against a memory-image model.
module tb_cpu_mem_responder;
    import cpu_mem_pkg::*;

    localparam int IW  = 1024;
    localparam int DW  = 1152;
    localparam int DAW = 11;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    pc;
    wire  [31:0]    inst;
    logic [63:0]    addr;
    logic           mem_rw;
    wire  [63:0]    mem_data;
    logic           halt;
    wire            cpu_rst;
    logic           prog_we;
    logic           prog_sel;
    logic [DAW-1:0] prog_addr;
    logic [63:0]    prog_data;
    logic           start;
    wire            dump_valid;
    logic           dump_ready;
    wire  [DAW-1:0] dump_addr;
    wire  [63:0]    dump_data;
    wire            done;

    logic [63:0] tb_bus;
    assign mem_data = mem_rw ? tb_bus : {64{1'bz}};

    int errors = 0;
    int checks = 0;

    // Reference memory images
    logic [31:0] m_imem [IW];
    logic [63:0] m_dmem [DW];

    cpu_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .inst       (inst),
        .addr       (addr),
        .mem_rw     (mem_rw),
        .mem_data   (mem_data),
        .halt       (halt),
        .cpu_rst    (cpu_rst),
        .prog_we    (prog_we),
        .prog_sel   (prog_sel),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start      (start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] m_read(input logic [63:0] a);
        if (a >= 64'(DW) * 64'd8) return 64'h0;
        return m_dmem[int'(a >> 3)];
    endfunction

    function automatic logic [31:0] m_fetch(input logic [31:0] p, input bit running);
        if (!running) return NOP_INST;
        if (p >= 32'(IW) * 32'd4) return HALT_INST;
        return m_imem[int'(p >> 2)];
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
        checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL reset_dump_valid: got %b want 0", dump_valid); end
        checks++; if (dump_addr !== '0) begin errors++; $display("FAIL reset_dump_addr: got %0d want 0", dump_addr); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (inst !== NOP_INST) begin errors++; $display("FAIL reset_inst: got %h want %h", inst, NOP_INST); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_preload();
        logic [63:0] d;
        prog_we = 1'b1;
        prog_sel = 1'b0;
        for (int i = 0; i < IW; i++) begin
            d = rnd64();
            if (i == 0) d = 64'hFFFF_FFFF_0050_0093;
            prog_addr = DAW'(i);
            prog_data = d;
            step();
            m_imem[i] = d[31:0];
        end
        // Out-of-range instruction write must not alias onto word 0
        prog_addr = DAW'(IW);
        prog_data = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        prog_sel = 1'b1;
        for (int i = 0; i < DW; i++) begin
            d = (i == DW - 1) ? 64'd7 : rnd64();
            prog_addr = DAW'(i);
            prog_data = d;
            step();
            m_dmem[i] = d;
        end
        prog_we = 1'b0;
        pc = 32'h0;
        #1;
        checks++; if (inst !== NOP_INST) begin errors++; $display("FAIL load_inst_nop: got %h want %h", inst, NOP_INST); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL load_cpu_rst: got %b want 1", cpu_rst); end
        addr = 64'd9208;
        #1;
        checks++; if (mem_data !== 64'd7) begin errors++; $display("FAIL load_read_9208: got %h want 7", mem_data); end
        for (int i = 0; i < 4; i++) begin
            addr = 64'($urandom_range(0, DW * 8 - 1));
            #1;
            checks++; if (mem_data !== m_read(addr)) begin errors++; $display("FAIL load_read addr=%0d: got %h want %h", addr, mem_data, m_read(addr)); end
        end
    endtask

    task automatic test_prog_with_start();
        logic [63:0] d;
        d = rnd64();
        prog_we = 1'b1;
        prog_sel = 1'b1;
        prog_addr = DAW'(5);
        prog_data = d;
        start = 1'b1;
        step();
        m_dmem[5] = d;
        prog_we = 1'b0;
        start = 1'b0;
        pc = 32'h0;
        addr = 64'd43;
        #1;
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL start_cpu_rst: got %b want 0", cpu_rst); end
        checks++; if (inst !== 32'h0050_0093) begin errors++; $display("FAIL start_inst0: got %h want 00500093", inst); end
        checks++; if (mem_data !== m_read(addr)) begin errors++; $display("FAIL prog_with_start_word: got %h want %h", mem_data, m_read(addr)); end
    endtask

    task automatic test_fetch();
        logic [31:0] p;
        pc = 32'd4096;
        #1;
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL fetch_4096: got %h want 0", inst); end
        pc = 32'hFFFF_FFFC;
        #1;
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL fetch_top: got %h want 0", inst); end
        for (int i = 0; i < 24; i++) begin
            p = (i % 6 == 5) ? $urandom : 32'($urandom_range(0, IW * 4 - 1));
            pc = p;
            #1;
            checks++; if (inst !== m_fetch(p, 1'b1)) begin errors++; $display("FAIL fetch pc=%h: got %h want %h", p, inst, m_fetch(p, 1'b1)); end
        end
    endtask

    task automatic test_store_load();
        logic [63:0] a;
        logic [63:0] d;
        addr = 64'd16;
        tb_bus = 64'hDEAD_BEEF_0000_0001;
        mem_rw = 1'b1;
        #1;
        checks++; if (mem_data !== tb_bus) begin errors++; $display("FAIL store_bus_released: got %h want %h", mem_data, tb_bus); end
        step();
        m_dmem[2] = 64'hDEAD_BEEF_0000_0001;
        mem_rw = 1'b0;
        addr = 64'd19;
        #1;
        checks++; if (mem_data !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL store_then_load: got %h want deadbeef00000001", mem_data); end
        // Out-of-range stores, including one whose low index bits alias word 1
        mem_rw = 1'b1;
        addr = 64'd9216;
        tb_bus = 64'h1234;
        step();
        addr = 64'h1_0000_0008;
        tb_bus = ~m_dmem[1];
        step();
        mem_rw = 1'b0;
        addr = 64'd9216;
        #1;
        checks++; if (mem_data !== 64'h0) begin errors++; $display("FAIL read_9216: got %h want 0", mem_data); end
        addr = 64'd8;
        #1;
        checks++; if (mem_data !== m_dmem[1]) begin errors++; $display("FAIL oob_alias_word1: got %h want %h", mem_data, m_dmem[1]); end
        addr = 64'h1_0000_0008;
        #1;
        checks++; if (mem_data !== 64'h0) begin errors++; $display("FAIL read_huge_addr: got %h want 0", mem_data); end
        for (int i = 0; i < 60; i++) begin
            a = ($urandom % 4 == 0) ? (64'(DW * 8) + 64'($urandom)) : 64'($urandom_range(0, DW * 8 - 1));
            addr = a;
            if ($urandom % 2 == 0) begin
                d = rnd64();
                mem_rw = 1'b1;
                tb_bus = d;
                step();
                if (a < 64'(DW * 8)) m_dmem[int'(a >> 3)] = d;
                mem_rw = 1'b0;
            end else begin
                #1;
                checks++; if (mem_data !== m_read(a)) begin errors++; $display("FAIL rand_load addr=%h: got %h want %h", a, mem_data, m_read(a)); end
            end
        end
    endtask

    task automatic test_prog_in_run();
        prog_we = 1'b1;
        prog_sel = 1'b1;
        prog_addr = DAW'(3);
        prog_data = ~m_dmem[3];
        start = 1'b1;
        step();
        prog_sel = 1'b0;
        prog_addr = DAW'(1);
        prog_data = {32'h0, ~m_imem[1]};
        step();
        prog_we = 1'b0;
        start = 1'b0;
        addr = 64'd24;
        pc = 32'd4;
        #1;
        checks++; if (mem_data !== m_dmem[3]) begin errors++; $display("FAIL prog_in_run_dmem: got %h want %h", mem_data, m_dmem[3]); end
        checks++; if (inst !== m_imem[1]) begin errors++; $display("FAIL prog_in_run_imem: got %h want %h", inst, m_imem[1]); end
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL start_in_run: got cpu_rst=%b want 0", cpu_rst); end
    endtask

    task automatic test_halt_and_reset_mid_dump();
        logic [63:0] a1, a2, d1, d2;
        int exp;
        a1 = 64'($urandom_range(0, DW * 8 - 1));
        a2 = 64'($urandom_range(0, DW * 8 - 1));
        d1 = rnd64();
        d2 = rnd64();
        // Store on the halt edge, then another store in DRAIN; both must commit
        mem_rw = 1'b1; addr = a1; tb_bus = d1; halt = 1'b1; dump_ready = 1'b0;
        step();
        m_dmem[int'(a1 >> 3)] = d1;
        halt = 1'b0;
        addr = a2; tb_bus = d2;
        pc = 32'h0;
        #1;
        checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL drain_dump_valid: got %b want 0", dump_valid); end
        checks++; if (inst !== NOP_INST) begin errors++; $display("FAIL drain_inst: got %h want %h", inst, NOP_INST); end
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL drain_cpu_rst: got %b want 0", cpu_rst); end
        step();
        m_dmem[int'(a2 >> 3)] = d2;
        checks++; if (dump_valid !== 1'b1) begin errors++; $display("FAIL dump_valid_n2: got %b want 1", dump_valid); end
        checks++; if (dump_addr !== '0) begin errors++; $display("FAIL dump_start_addr: got %0d want 0", dump_addr); end
        // Store attempt during DUMP is dropped
        tb_bus = ~d2;
        halt = 1'b1;
        step();
        mem_rw = 1'b0;
        halt = 1'b0;
        #1;
        checks++; if (mem_data !== m_read(a2)) begin errors++; $display("FAIL dump_store_dropped: got %h want %h", mem_data, m_read(a2)); end
        exp = 0;
        for (int cyc = 0; cyc < 4000 && exp < 40; cyc++) begin
            checks++; if (dump_valid !== 1'b1 || dump_addr !== DAW'(exp)) begin errors++; $display("FAIL stall_dump_addr: got v=%b a=%0d want v=1 a=%0d", dump_valid, dump_addr, exp); end
            checks++; if (dump_data !== m_dmem[exp]) begin errors++; $display("FAIL stall_dump_data[%0d]: got %h want %h", exp, dump_data, m_dmem[exp]); end
            dump_ready = 1'($urandom % 2);
            start = 1'($urandom % 2);
            step();
            if (dump_ready) exp++;
        end
        dump_ready = 1'b0;
        start = 1'b0;
        checks++; if (exp != 40 || dump_addr !== DAW'(40)) begin errors++; $display("FAIL stall_reach_40: got exp=%0d addr=%0d want 40", exp, dump_addr); end
        rst = 1'b1;
        #1;
        checks++; if (dump_valid !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL mid_dump_reset: got v=%b cpu_rst=%b done=%b want 0 1 0", dump_valid, cpu_rst, done); end
        checks++; if (dump_addr !== '0) begin errors++; $display("FAIL mid_dump_reset_addr: got %0d want 0", dump_addr); end
        mem_rw = 1'b1; addr = 64'd0; tb_bus = ~m_dmem[0];
        step();
        mem_rw = 1'b0;
        rst = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            addr = (i == 0) ? 64'd0 : 64'($urandom_range(0, DW * 8 - 1));
            #1;
            checks++; if (mem_data !== m_read(addr)) begin errors++; $display("FAIL preserved addr=%0d: got %h want %h", addr, mem_data, m_read(addr)); end
        end
    endtask

    task automatic test_full_dump();
        int exp;
        start = 1'b1;
        step();
        start = 1'b0;
        halt = 1'b1;
        step();
        halt = 1'b0;
        dump_ready = 1'b1;
        step();
        exp = 0;
        for (int cyc = 0; cyc < DW + 10 && done !== 1'b1; cyc++) begin
            checks++; if (dump_valid !== 1'b1 || dump_addr !== DAW'(exp)) begin errors++; $display("FAIL full_dump_addr: got v=%b a=%0d want v=1 a=%0d", dump_valid, dump_addr, exp); end
            checks++; if (dump_data !== m_dmem[exp % DW]) begin errors++; $display("FAIL full_dump_data[%0d]: got %h want %h", exp, dump_data, m_dmem[exp % DW]); end
            step();
            exp++;
        end
        checks++; if (exp != DW) begin errors++; $display("FAIL full_dump_beats: got %0d want %0d", exp, DW); end
        checks++; if (done !== 1'b1 || dump_valid !== 1'b0) begin errors++; $display("FAIL done_state: got done=%b v=%b want 1 0", done, dump_valid); end
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin errors++; $display("FAIL done_holds: got done=%b cpu_rst=%b want 1 0", done, cpu_rst); end
        rst = 1'b1;
        #1;
        checks++; if (done !== 1'b0 || cpu_rst !== 1'b1) begin errors++; $display("FAIL done_reset: got done=%b cpu_rst=%b want 0 1", done, cpu_rst); end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc = '0; addr = '0; mem_rw = 1'b0; tb_bus = '0; halt = 1'b0;
        prog_we = 1'b0; prog_sel = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; dump_ready = 1'b0;
        test_reset();
        test_preload();
        test_prog_with_start();
        test_fetch();
        test_store_load();
        test_prog_in_run();
        test_halt_and_reset_mid_dump();
        test_full_dump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
